// File: rtl/network_mac_pipe.sv
// network_mac_pipe: pipelined signed multiply-accumulate over first/last framed beats, then round-half-up, shift, narrow.
// Build option NETWORK_MAC_SAT_EN: saturate the narrowed result and flag ovf; otherwise the result wraps and ovf is 0.
module network_mac_pipe #(
  parameter int ID        = 1,
  parameter int A_W       = 16,
  parameter int B_W       = 11,
  parameter int B_SIGNED  = 0,
  parameter int NUM_STAGE = 3,
  parameter int ACC_W     = 40,
  parameter int SHIFT     = 10,
  parameter int OUT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             first,
  input  logic             last,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);
  localparam int P_W = A_W + B_W;
  localparam int R_W = ACC_W + 1;
  // Half of one output LSB; zero when there is no shift.
  localparam logic [R_W-1:0] RND = (R_W'(1) << SHIFT) >> 1;

  if (ID < 0 || NUM_STAGE < 2 || ACC_W < P_W || SHIFT < 0 || SHIFT >= ACC_W || OUT_W > ACC_W)
  begin : g_bad_param
    $error("network_mac_pipe: illegal parameter set");
  end

  logic signed [A_W-1:0]   a_q, a_d;
  logic        [B_W-1:0]   b_q, b_d;
  logic signed [P_W-1:0]   a_ext, b_ext;
  logic signed [P_W-1:0]   p_q [2:NUM_STAGE];
  logic signed [P_W-1:0]   p_d [2:NUM_STAGE];
  logic [NUM_STAGE:1]      v_q, v_d, f_q, f_d, l_q, l_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic signed [R_W-1:0]   sum_r;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        dout_q, dout_d;
`ifdef NETWORK_MAC_SAT_EN
  localparam logic signed [R_W-1:0] SAT_MAX = (R_W'(1) << (OUT_W-1)) - R_W'(1);
  localparam logic signed [R_W-1:0] SAT_MIN = -(R_W'(1) << (OUT_W-1));
  logic signed [R_W-1:0]   r;
  logic                    ovf_q, ovf_d;
`endif

  always_comb begin
    a_d = din0;
    b_d = din1;
    v_d = {v_q[NUM_STAGE-1:1], in_valid};
    f_d = {f_q[NUM_STAGE-1:1], first};
    l_d = {l_q[NUM_STAGE-1:1], last};

    // Operands widened to the product width so the multiply is exact.
    a_ext = P_W'(a_q);
    b_ext = (B_SIGNED != 0) ? P_W'($signed(b_q)) : P_W'({1'b0, b_q});
    p_d[2] = a_ext * b_ext;
    for (int s = 3; s <= NUM_STAGE; s++) p_d[s] = p_q[s-1];

    acc_sum = f_q[NUM_STAGE] ? ACC_W'(p_q[NUM_STAGE]) : acc_q + ACC_W'(p_q[NUM_STAGE]);
    acc_d   = v_q[NUM_STAGE] ? acc_sum : acc_q;
    sum_r   = R_W'(acc_sum) + RND;

    out_valid_d = v_q[NUM_STAGE] & l_q[NUM_STAGE];
    dout_d      = dout_q;
`ifdef NETWORK_MAC_SAT_EN
    r     = sum_r >>> SHIFT;
    ovf_d = 1'b0;
    if (out_valid_d) begin
      if (r > SAT_MAX) begin
        dout_d = SAT_MAX[OUT_W-1:0];
        ovf_d  = 1'b1;
      end else if (r < SAT_MIN) begin
        dout_d = SAT_MIN[OUT_W-1:0];
        ovf_d  = 1'b1;
      end else begin
        dout_d = r[OUT_W-1:0];
      end
    end
`else
    if (out_valid_d) dout_d = OUT_W'(sum_r >>> SHIFT);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q         <= '0;
      f_q         <= '0;
      l_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
`ifdef NETWORK_MAC_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else if (ce) begin
      v_q         <= v_d;
      f_q         <= f_d;
      l_q         <= l_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
`ifdef NETWORK_MAC_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Data stages need no reset: their valid tags gate every use.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
`ifdef NETWORK_MAC_SAT_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_network_mac_pipe.sv
// Randomised and directed bench for network_mac_pipe: three instances (unsigned 11-bit weight, signed 8-bit weight
// with SHIFT 10 and SHIFT 0) checked against an arithmetic model of framed sums, rounding and narrowing.
`timescale 1ns/1ps
module tb_network_mac_pipe;
  logic        clk = 1'b0;
  logic        reset, ce, in_valid, first, last;
  logic [15:0] din0;
  logic [10:0] din1_w;
  logic [7:0]  din1_n;
  logic        ov_a   [3];
  logic [15:0] dout_a [3];
  logic        ovf_a  [3];

  always #5 clk = ~clk;

  network_mac_pipe u_dut0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .first(first), .last(last),
    .din0(din0), .din1(din1_w), .out_valid(ov_a[0]), .dout(dout_a[0]), .ovf(ovf_a[0]));
  network_mac_pipe #(.B_W(8), .B_SIGNED(1)) u_dut1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .first(first), .last(last),
    .din0(din0), .din1(din1_n), .out_valid(ov_a[1]), .dout(dout_a[1]), .ovf(ovf_a[1]));
  network_mac_pipe #(.B_W(8), .B_SIGNED(1), .SHIFT(0)) u_dut2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .first(first), .last(last),
    .din0(din0), .din1(din1_n), .out_valid(ov_a[2]), .dout(dout_a[2]), .ovf(ovf_a[2]));

  int     n_cmp = 0, n_bad = 0;
  int     en_cnt = 0;
  longint acc_m [3];
  longint q_d [3][256];
  bit     q_o [3][256];
  int     q_due [3][256];
  int     q_hd [3], q_tl [3];
  longint last_d [3];
  bit     last_o [3];
  int     n_res [3];
  longint res_hist [3][256];
  int     res_edge [3][256];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap40(input longint x);
    longint m;
    m = x & ((longint'(1) << 40) - 1);
    if (m[39]) m = m - (longint'(1) << 40);
    return m;
  endfunction

  // Round half up, shift, then narrow to 16 bits: a sum of whole numbers, not bit fiddling.
  task automatic push_expect(input int i, input longint acc, input int due);
    int     sh;
    longint r, d;
    bit     o;
    sh = (i == 2) ? 0 : 10;
    r  = acc;
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    r = r >>> sh;
`ifdef NETWORK_MAC_SAT_EN
    if (r > 32767) begin d = 32767; o = 1; end
    else if (r < -32768) begin d = -32768; o = 1; end
    else begin d = r; o = 0; end
`else
    d = r & 65535;
    if (d >= 32768) d = d - 65536;
    o = 0;
`endif
    q_d[i][q_tl[i] % 256]   = d;
    q_o[i][q_tl[i] % 256]   = o;
    q_due[i][q_tl[i] % 256] = due;
    q_tl[i]++;
  endtask

  // One clock: check outputs as they stand, advance the model for this edge, drive inputs, move to next negedge.
  task automatic step(input bit c, input bit r, input bit v, input bit f, input bit l,
                      input int a, input int bw, input int bn);
    longint p;
    longint got;
    bit     due;
    if (c) begin
      for (int i = 0; i < 3; i++) begin
        due = (q_hd[i] != q_tl[i]) && (q_due[i][q_hd[i] % 256] == en_cnt + 1);
        got = longint'($signed(dout_a[i]));
        chk($sformatf("valid%0d@%0d", i, en_cnt), longint'(ov_a[i]), longint'(due));
        if (ov_a[i] && due) begin
          chk($sformatf("dout%0d@%0d", i, en_cnt), got, q_d[i][q_hd[i] % 256]);
          chk($sformatf("ovf%0d@%0d", i, en_cnt), longint'(ovf_a[i]), longint'(q_o[i][q_hd[i] % 256]));
          last_d[i] = q_d[i][q_hd[i] % 256];
          last_o[i] = q_o[i][q_hd[i] % 256];
          res_hist[i][n_res[i] % 256] = got;
          res_edge[i][n_res[i] % 256] = en_cnt + 1;
          n_res[i]++;
          q_hd[i]++;
        end else begin
          chk($sformatf("hold%0d@%0d", i, en_cnt), got, last_d[i]);
        end
      end
    end
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        acc_m[i] = 0; q_hd[i] = q_tl[i]; last_d[i] = 0; last_o[i] = 0;
      end
    end else if (c) begin
      en_cnt++;
      if (v) begin
        for (int i = 0; i < 3; i++) begin
          p = longint'(a) * ((i == 0) ? longint'(bw) : longint'(bn));
          acc_m[i] = wrap40(f ? p : acc_m[i] + p);
          if (l) push_expect(i, acc_m[i], en_cnt + 4);
        end
      end
    end
    reset = r; ce = c; in_valid = v; first = f; last = l;
    din0 = 16'(a); din1_w = 11'(bw); din1_n = 8'(bn);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input int a, input int bw, input int bn, input bit f, input bit l);
    step(1'b1, 1'b0, 1'b1, f, l, a, bw, bn);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    int n0, n1, n2, e_beat;
    for (int i = 0; i < 3; i++) begin
      acc_m[i] = 0; q_hd[i] = 0; q_tl[i] = 0; last_d[i] = 0; last_o[i] = 0; n_res[i] = 0;
    end
    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; first = 1'b0; last = 1'b0;
    din0 = '0; din1_w = '0; din1_n = '0;
    @(negedge clk);
    // Reset must act with ce low.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("rst_valid", longint'(ov_a[0]), 0);
    chk("rst_dout", longint'($signed(dout_a[0])), 0);
    chk("rst_ovf", longint'(ovf_a[0]), 0);
    idle(2);

    n0 = n_res[0];
    beat(-3, 2047, -1, 1'b1, 1'b1);
    e_beat = en_cnt;
    idle(5);
    chk("single_cnt", n_res[0] - n0, 1);
    chk("single_dout", last_d[0], -6);
    chk("single_ovf", longint'(last_o[0]), 0);
    chk("single_lat", res_edge[0][n0 % 256] - e_beat, 4);

    n0 = n_res[0];
    for (int k = 0; k < 4; k++) beat(1024, k + 1, k + 1, k == 0, k == 3);
    idle(5);
    chk("dot_cnt", n_res[0] - n0, 1);
    chk("dot_dout", last_d[0], 10);

    n0 = n_res[0];
    for (int k = 0; k < 8; k++) beat(32767, 2047, 127, k == 0, k == 7);
    idle(5);
    chk("ovfl_cnt", n_res[0] - n0, 1);
`ifdef NETWORK_MAC_SAT_EN
    chk("ovfl_dout", last_d[0], 32767);
    chk("ovfl_flag", longint'(last_o[0]), 1);
`else
    chk("ovfl_dout", last_d[0], -272);
    chk("ovfl_flag", longint'(last_o[0]), 0);
`endif

    n0 = n_res[0];
    beat(1024, 1, 1, 1'b1, 1'b0);
    beat(1024, 2, 2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 999, 77, 77);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -999, 5, 5);
    beat(1024, 3, 3, 1'b0, 1'b0);
    beat(1024, 4, 4, 1'b0, 1'b1);
    idle(3);
    chk("stall_pre", longint'(ov_a[0]), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("stall_hold", longint'(ov_a[0]), 1);
    idle(4);
    chk("stall_cnt", n_res[0] - n0, 1);
    chk("stall_dout", last_d[0], 10);

    n0 = n_res[0];
    beat(1000, 5, 5, 1'b1, 1'b0);
    beat(1000, 5, 5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    beat(2048, 1, 1, 1'b1, 1'b1);
    idle(5);
    chk("rstmid_cnt", n_res[0] - n0, 1);
    chk("rstmid_dout", last_d[0], 2);

    n1 = n_res[1]; n2 = n_res[2];
    beat(100, 0, -2, 1'b1, 1'b1);
    beat(50, 0, -4, 1'b1, 1'b1);
    idle(5);
    chk("b2b_cnt_s10", n_res[1] - n1, 2);
    chk("b2b_a_s10", res_hist[1][n1 % 256], 0);
    chk("b2b_b_s10", res_hist[1][(n1 + 1) % 256], 0);
    chk("b2b_cnt_s0", n_res[2] - n2, 2);
    chk("b2b_a_s0", res_hist[2][n2 % 256], -200);
    chk("b2b_b_s0", res_hist[2][(n2 + 1) % 256], -200);
    chk("b2b_gap", res_edge[2][(n2 + 1) % 256] - res_edge[2][n2 % 256], 1);

    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 10) != 0, ($urandom % 100) == 0, ($urandom % 5) != 0,
           ($urandom % 4) == 0, ($urandom % 4) == 0,
           int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 2047)),
           int'($urandom_range(0, 255)) - 128);
    end
    idle(8);
    for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), q_tl[i] - q_hd[i], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
